// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared types and constants for the VGA drawing pipeline,
//            including the end-of-game result overlay.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Trophy sprite dimensions, in cells
  localparam int SPR_W = 16;
  localparam int SPR_H = 14;

  typedef enum logic [1:0] {
    RES_WHITE = 2'd0,
    RES_BLACK = 2'd1,
    RES_DRAW  = 2'd2
  } result_t;

  typedef enum logic [1:0] {
    OVL_IDLE   = 2'd0,
    OVL_REVEAL = 2'd1,
    OVL_SHOW   = 2'd2
  } ovl_state_t;

  // Sprite cell codes
  localparam logic [1:0] CELL_CLEAR   = 2'd0;
  localparam logic [1:0] CELL_OUTLINE = 2'd1;
  localparam logic [1:0] CELL_FILL    = 2'd2;
  localparam logic [1:0] CELL_ACCENT  = 2'd3;

  // Overlay palette (fill / outline / accent / background per result)
  localparam logic [11:0] COL_WHITE_FILL    = 12'hfff;
  localparam logic [11:0] COL_WHITE_OUTLINE = 12'h666;
  localparam logic [11:0] COL_WHITE_BG      = 12'h0f0;
  localparam logic [11:0] COL_BLACK_FILL    = 12'h000;
  localparam logic [11:0] COL_BLACK_OUTLINE = 12'h888;
  localparam logic [11:0] COL_BLACK_BG      = 12'hf00;
  localparam logic [11:0] COL_DRAW_FILL     = 12'h888;
  localparam logic [11:0] COL_DRAW_OUTLINE  = 12'h444;
  localparam logic [11:0] COL_DRAW_BG       = 12'h00f;
  localparam logic [11:0] COL_ACCENT        = 12'hfd0;

  // Both wins together, or an explicit draw, count as a draw
  function automatic result_t resolve_result(input logic w, input logic b, input logic d);
    if ((w && b) || d) return RES_DRAW;
    else if (w)        return RES_WHITE;
    else               return RES_BLACK;
  endfunction

  // Cell code 0 (transparent) selects the background colour
  function automatic logic [11:0] overlay_colour(input result_t res, input logic [1:0] code);
    logic [11:0] fill;
    logic [11:0] outline;
    logic [11:0] bg;
    case (res)
      RES_WHITE: begin fill = COL_WHITE_FILL; outline = COL_WHITE_OUTLINE; bg = COL_WHITE_BG; end
      RES_BLACK: begin fill = COL_BLACK_FILL; outline = COL_BLACK_OUTLINE; bg = COL_BLACK_BG; end
      default:   begin fill = COL_DRAW_FILL;  outline = COL_DRAW_OUTLINE;  bg = COL_DRAW_BG;  end
    endcase
    case (code)
      CELL_OUTLINE: return outline;
      CELL_FILL:    return fill;
      CELL_ACCENT:  return COL_ACCENT;
      default:      return bg;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/trophy_rom.sv
`default_nettype none
// ============================================================================
// Module   : trophy_rom
// Purpose  : Combinational 16x14 trophy bitmap (cup, handles, stem, base).
//            Each row is 16 two-bit codes, column 0 in the top bits.
// Revision : 1.0 - initial release
// ============================================================================
module trophy_rom (
  input  logic [3:0] i_col,
  input  logic [3:0] i_row,
  output logic [1:0] o_code
);

  logic [31:0] w_bits;

  // Row lookup: . = 0, o = 1 (outline), # = 2 (fill), * = 3 (accent)
  always_comb begin
    w_bits = 32'h0000_0000;
    case (i_row)
      4'd0:  w_bits = 32'h0555_5550; // ..oooooooooooo..
      4'd1:  w_bits = 32'h57AA_AAD5; // ooo*########*ooo
      4'd2:  w_bits = 32'h47AA_AAD1; // o.o*########*o.o
      4'd3:  w_bits = 32'h46AA_AA91; // o.o##########o.o
      4'd4:  w_bits = 32'h46AA_AA91; // o.o##########o.o
      4'd5:  w_bits = 32'h56AA_AA95; // ooo##########ooo
      4'd6:  w_bits = 32'h06AA_AA90; // ..o##########o..
      4'd7:  w_bits = 32'h01AA_AA40; // ...o########o...
      4'd8:  w_bits = 32'h005A_A500; // ....oo####oo....
      4'd9:  w_bits = 32'h0006_9000; // ......o##o......
      4'd10: w_bits = 32'h0007_D000; // ......o**o......
      4'd11: w_bits = 32'h0055_5500; // ....oooooooo....
      4'd12: w_bits = 32'h007F_FD00; // ....o******o....
      4'd13: w_bits = 32'h0155_5540; // ...oooooooooo...
      default: w_bits = 32'h0000_0000;
    endcase
  end

  // Column 0 sits in bits [31:30], column 15 in bits [1:0]
  assign o_code = w_bits[{~i_col, 1'b0} +: 2];

endmodule
`default_nettype wire

// File: rtl/draw_result_overlay.sv
`default_nettype none
// ============================================================================
// Module   : draw_result_overlay
// Purpose  : End-of-game overlay. Latches the game result, reveals a scaled
//            trophy sprite bottom-up one row at a time, then blinks the
//            background until cleared. Two-cycle pipeline on every field.
// Revision : 1.0 - initial release
// ============================================================================
module draw_result_overlay
  import vga_pkg::*;
#(
  parameter int X_POS         = 272,
  parameter int Y_POS         = 332,
  parameter int SCALE_LOG2    = 4,
  parameter int REVEAL_FRAMES = 4,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        white_win,
  input  logic        black_win,
  input  logic        draw_game,
  input  logic        clear,
  input  logic [10:0] vga_in_hcount,
  input  logic [10:0] vga_in_vcount,
  input  logic        vga_in_hsync,
  input  logic        vga_in_vsync,
  input  logic        vga_in_hblnk,
  input  logic        vga_in_vblnk,
  input  logic [11:0] vga_in_rgb,
  output logic [10:0] vga_out_hcount,
  output logic [10:0] vga_out_vcount,
  output logic        vga_out_hsync,
  output logic        vga_out_vsync,
  output logic        vga_out_hblnk,
  output logic        vga_out_vblnk,
  output logic [11:0] vga_out_rgb,
  output logic        busy
);

  localparam logic [1:0]  ST_IDLE   = OVL_IDLE;
  localparam logic [1:0]  ST_REVEAL = OVL_REVEAL;
  localparam logic [1:0]  ST_SHOW   = OVL_SHOW;
  localparam int          CNT_W     = 16;
  localparam logic [3:0]  ROWS_ALL  = 4'(SPR_H);

  // Control state
  logic [1:0]       r_state;
  result_t          r_res;
  logic [3:0]       r_rows;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_blink;
  logic             r_vblnk_prev;

  // Stage-1 registers
  logic [10:0] r_s1_hcount;
  logic [10:0] r_s1_vcount;
  logic        r_s1_hsync;
  logic        r_s1_vsync;
  logic        r_s1_hblnk;
  logic        r_s1_vblnk;
  logic [11:0] r_s1_rgb;
  logic [1:0]  r_s1_code;
  logic        r_s1_vis;
  logic        r_s1_active;
  result_t     r_s1_res;
  logic        r_s1_blink;

  // Combinational
  logic        w_tick;
  logic        w_any_result;
  logic [11:0] w_dx;
  logic [11:0] w_dy;
  logic [11:0] w_dx_cell;
  logic [11:0] w_dy_cell;
  logic        w_in_spr;
  logic        w_row_vis;
  logic [1:0]  w_code;
  logic [1:0]  w_cell;
  logic [11:0] w_base;
  logic [11:0] w_rgb;

  assign w_tick       = vga_in_vblnk & ~r_vblnk_prev;
  assign w_any_result = white_win | black_win | draw_game;
  assign busy         = (r_state != ST_IDLE);

  // Sprite-relative cell coordinates, computed at 12 bits so underflow wraps high
  assign w_dx      = {1'b0, vga_in_hcount} - 12'(X_POS);
  assign w_dy      = {1'b0, vga_in_vcount} - 12'(Y_POS);
  assign w_dx_cell = w_dx >> SCALE_LOG2;
  assign w_dy_cell = w_dy >> SCALE_LOG2;
  assign w_in_spr  = ({1'b0, vga_in_hcount} >= 12'(X_POS)) &&
                     ({1'b0, vga_in_vcount} >= 12'(Y_POS)) &&
                     (w_dx_cell < 12'(SPR_W)) && (w_dy_cell < 12'(SPR_H));
  assign w_row_vis = (r_state == ST_SHOW) ||
                     ((r_state == ST_REVEAL) &&
                      (({1'b0, w_dy_cell[3:0]} + {1'b0, r_rows}) >= 5'(SPR_H)));

  trophy_rom u_rom (
    .i_col  (w_dx_cell[3:0]),
    .i_row  (w_dy_cell[3:0]),
    .o_code (w_code)
  );

  // Result latch, reveal/blink sequencing and frame-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_res        <= RES_WHITE;
      r_rows       <= 4'd0;
      r_frame_cnt  <= '0;
      r_blink      <= 1'b0;
      r_vblnk_prev <= 1'b0;
    end else begin
      r_vblnk_prev <= vga_in_vblnk;
      if (clear) begin
        r_state     <= ST_IDLE;
        r_rows      <= 4'd0;
        r_frame_cnt <= '0;
        r_blink     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_any_result) begin
              r_res       <= resolve_result(white_win, black_win, draw_game);
              r_state     <= ST_REVEAL;
              r_rows      <= 4'd0;
              r_frame_cnt <= '0;
              r_blink     <= 1'b0;
            end
          end
          ST_REVEAL: begin
            if (w_tick) begin
              if (r_frame_cnt == CNT_W'(REVEAL_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_rows      <= r_rows + 4'd1;
                if (r_rows == ROWS_ALL - 4'd1) r_state <= ST_SHOW;
              end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
              end
            end
          end
          ST_SHOW: begin
            if (w_tick) begin
              if (r_frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                r_frame_cnt <= '0;
                r_blink     <= ~r_blink;
              end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Stage 1: timing, cell code, visibility and a snapshot of overlay state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_hcount <= '0;
      r_s1_vcount <= '0;
      r_s1_hsync  <= 1'b0;
      r_s1_vsync  <= 1'b0;
      r_s1_hblnk  <= 1'b0;
      r_s1_vblnk  <= 1'b0;
      r_s1_rgb    <= '0;
      r_s1_code   <= 2'd0;
      r_s1_vis    <= 1'b0;
      r_s1_active <= 1'b0;
      r_s1_res    <= RES_WHITE;
      r_s1_blink  <= 1'b0;
    end else begin
      r_s1_hcount <= vga_in_hcount;
      r_s1_vcount <= vga_in_vcount;
      r_s1_hsync  <= vga_in_hsync;
      r_s1_vsync  <= vga_in_vsync;
      r_s1_hblnk  <= vga_in_hblnk;
      r_s1_vblnk  <= vga_in_vblnk;
      r_s1_rgb    <= vga_in_rgb;
      r_s1_code   <= w_code;
      r_s1_vis    <= w_in_spr && w_row_vis;
      r_s1_active <= (r_state != ST_IDLE);
      r_s1_res    <= r_res;
      r_s1_blink  <= (r_state == ST_SHOW) && r_blink;
    end
  end

  assign w_cell = (r_s1_vis && (r_s1_code != CELL_CLEAR)) ? r_s1_code : CELL_CLEAR;
  assign w_base = overlay_colour(r_s1_res, w_cell);

  // Stage-2 colour select: pass-through, blanking, sprite cell or background
  always_comb begin
    w_rgb = r_s1_rgb;
    if (r_s1_active) begin
      if (r_s1_hblnk || r_s1_vblnk) begin
        w_rgb = 12'h000;
      end else if ((w_cell == CELL_CLEAR) && r_s1_blink) begin
        w_rgb = {1'b0, w_base[11:9], 1'b0, w_base[7:5], 1'b0, w_base[3:1]};
      end else begin
        w_rgb = w_base;
      end
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out_hcount <= '0;
      vga_out_vcount <= '0;
      vga_out_hsync  <= 1'b0;
      vga_out_vsync  <= 1'b0;
      vga_out_hblnk  <= 1'b0;
      vga_out_vblnk  <= 1'b0;
      vga_out_rgb    <= '0;
    end else begin
      vga_out_hcount <= r_s1_hcount;
      vga_out_vcount <= r_s1_vcount;
      vga_out_hsync  <= r_s1_hsync;
      vga_out_vsync  <= r_s1_vsync;
      vga_out_hblnk  <= r_s1_hblnk;
      vga_out_vblnk  <= r_s1_vblnk;
      vga_out_rgb    <= w_rgb;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_result_overlay.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_result_overlay
// Purpose  : Randomised scoreboard bench for draw_result_overlay against a
//            tick-count based reference model of the overlay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_result_overlay;

  localparam int XP = 272;
  localparam int YP = 332;
  localparam int SC = 4;
  localparam int RF = 4;
  localparam int BF = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        white_win = 1'b0, black_win = 1'b0, draw_game = 1'b0, clear = 1'b0;
  logic [10:0] in_hc = '0, in_vc = '0;
  logic        in_hs = 1'b0, in_vs = 1'b0, in_hb = 1'b0, in_vb = 1'b0;
  logic [11:0] in_rgb = '0;
  logic [10:0] out_hc, out_vc;
  logic        out_hs, out_vs, out_hb, out_vb;
  logic [11:0] out_rgb;
  logic        busy;

  draw_result_overlay dut (
    .clk(clk), .rst(rst),
    .white_win(white_win), .black_win(black_win), .draw_game(draw_game), .clear(clear),
    .vga_in_hcount(in_hc), .vga_in_vcount(in_vc), .vga_in_hsync(in_hs), .vga_in_vsync(in_vs),
    .vga_in_hblnk(in_hb), .vga_in_vblnk(in_vb), .vga_in_rgb(in_rgb),
    .vga_out_hcount(out_hc), .vga_out_vcount(out_vc), .vga_out_hsync(out_hs), .vga_out_vsync(out_vs),
    .vga_out_hblnk(out_hb), .vga_out_vblnk(out_vb), .vga_out_rgb(out_rgb),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [37:0] bus;
  } vexp_t;

  typedef struct {
    int   cyc;
    logic busy;
  } bexp_t;

  vexp_t q_vga[$];
  bexp_t q_busy[$];
  int    n_vec = 0;
  int    n_err = 0;

  // Reference model: overlay on/off, latched result, frame ticks since start
  bit m_active = 1'b0;
  int m_res    = 0;
  int m_ticks  = 0;
  bit m_prev   = 1'b0;

  string spr [14] = '{
    "..oooooooooooo..",
    "ooo*########*ooo",
    "o.o*########*o.o",
    "o.o##########o.o",
    "o.o##########o.o",
    "ooo##########ooo",
    "..o##########o..",
    "...o########o...",
    "....oo####oo....",
    "......o##o......",
    "......o**o......",
    "....oooooooo....",
    "....o******o....",
    "...oooooooooo..."
  };

  function automatic logic [11:0] ref_colour(int res, int code);
    logic [11:0] pal [3][4];
    pal[0] = '{12'h0f0, 12'h666, 12'hfff, 12'hfd0};
    pal[1] = '{12'hf00, 12'h888, 12'h000, 12'hfd0};
    pal[2] = '{12'h00f, 12'h444, 12'h888, 12'hfd0};
    return pal[res][code];
  endfunction

  function automatic logic [11:0] ref_pixel(int h, int v, bit hb, bit vb, logic [11:0] rgb);
    int    rows, col, row, code;
    bit    blink;
    string s;
    byte   ch;
    logic [11:0] c;
    if (!m_active) return rgb;
    if (hb || vb)  return 12'h000;
    rows  = m_ticks / RF;
    if (rows > 14) rows = 14;
    blink = (m_ticks >= 14 * RF) && ((((m_ticks - 14 * RF) / BF) % 2) == 1);
    code  = 0;
    if (h >= XP && v >= YP) begin
      col = (h - XP) >> SC;
      row = (v - YP) >> SC;
      if (col < 16 && row < 14 && row >= 14 - rows) begin
        s  = spr[row];
        ch = s[col];
        code = (ch == "o") ? 1 : (ch == "#") ? 2 : (ch == "*") ? 3 : 0;
      end
    end
    c = ref_colour(m_res, code);
    if (code == 0 && blink) c = {c[11:8] >> 1, c[7:4] >> 1, c[3:0] >> 1};
    return c;
  endfunction

  // Issue one cycle of stimulus: queue expectations, then advance the model
  task automatic step();
    vexp_t e, last;
    bexp_t b;
    bit    tick;
    e.cyc = cyc + 2;
    if (rst) begin
      e.bus = '0;
      if (q_vga.size() > 0 && q_vga[$].cyc == cyc + 1) begin
        last = q_vga.pop_back();
        last.bus = '0;
        q_vga.push_back(last);
      end
    end else begin
      e.bus = {in_hc, in_vc, in_hs, in_vs, in_hb, in_vb,
               ref_pixel(int'(in_hc), int'(in_vc), in_hb, in_vb, in_rgb)};
    end
    q_vga.push_back(e);
    b.cyc  = cyc;
    b.busy = m_active;
    q_busy.push_back(b);

    tick = in_vb && !m_prev;
    if (rst) begin
      m_active = 1'b0; m_res = 0; m_ticks = 0; m_prev = 1'b0;
    end else begin
      m_prev = in_vb;
      if (clear) begin
        m_active = 1'b0; m_ticks = 0;
      end else if (!m_active) begin
        if (white_win || black_win || draw_game) begin
          m_active = 1'b1;
          m_ticks  = 0;
          m_res    = ((white_win && black_win) || draw_game) ? 2 : (white_win ? 0 : 1);
        end
      end else if (tick) begin
        m_ticks++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pix();
    if ($urandom_range(0, 1) == 1) begin
      in_hc = 11'(XP - 8 + int'($urandom_range(0, 271)));
      in_vc = 11'(YP - 8 + int'($urandom_range(0, 239)));
    end else begin
      in_hc = 11'($urandom_range(0, 799));
      in_vc = 11'($urandom_range(0, 599));
    end
    in_hs  = 1'($urandom_range(0, 1));
    in_vs  = 1'($urandom_range(0, 1));
    in_hb  = ($urandom_range(0, 7) == 0);
    in_vb  = 1'b0;
    in_rgb = 12'($urandom);
  endtask

  task automatic pix_cycles(int n);
    repeat (n) begin rand_pix(); step(); end
  endtask

  task automatic run_ticks(int n);
    repeat (n) begin
      pix_cycles(5);
      rand_pix(); in_vb = 1'b1; step();
    end
    rand_pix(); step();
  endtask

  task automatic fixed_pix(int h, int v);
    in_hc = 11'(h); in_vc = 11'(v); in_hb = 1'b0; in_vb = 1'b0; in_rgb = 12'($urandom);
    step();
  endtask

  // Monitor: pop and compare each expectation in the cycle it falls due
  always @(negedge clk) begin
    while (q_busy.size() > 0 && q_busy[0].cyc <= cyc) begin
      bexp_t b;
      b = q_busy.pop_front();
      n_vec++;
      if (b.cyc != cyc || busy !== b.busy) begin
        n_err++;
        $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy, b.busy);
      end
    end
    while (q_vga.size() > 0 && q_vga[0].cyc <= cyc) begin
      vexp_t e;
      logic [37:0] got;
      e   = q_vga.pop_front();
      got = {out_hc, out_vc, out_hs, out_vs, out_hb, out_vb, out_rgb};
      n_vec++;
      if (e.cyc != cyc || got !== e.bus) begin
        n_err++;
        $display("FAIL vga_out cyc=%0d got hc=%0d vc=%0d sync/blnk=%b rgb=%h expected hc=%0d vc=%0d sync/blnk=%b rgb=%h",
                 cyc, got[37:27], got[26:16], got[15:12], got[11:0],
                 e.bus[37:27], e.bus[26:16], e.bus[15:12], e.bus[11:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset held three cycles: all outputs zero, busy low
    pix_cycles(3);
    rst = 1'b0;
    // Idle pass-through, including a known colour
    rand_pix(); in_rgb = 12'h123; step();
    pix_cycles(10);

    // White win: reveal row by row, then show and blink
    white_win = 1'b1; rand_pix(); step(); white_win = 1'b0;
    run_ticks(4);
    for (int c = 0; c < 16; c++) fixed_pix(XP + 16 * c + 3, 545);
    fixed_pix(XP + 40, 520);
    run_ticks(52);
    pix_cycles(6);
    run_ticks(32);
    fixed_pix(0, 0);

    // Result inputs ignored while showing
    black_win = 1'b1; pix_cycles(3); black_win = 1'b0;
    run_ticks(2);

    // Clear returns to pass-through
    clear = 1'b1; rand_pix(); step(); clear = 1'b0;
    pix_cycles(8);

    // Both wins together resolve to a draw
    white_win = 1'b1; black_win = 1'b1; rand_pix(); step();
    white_win = 1'b0; black_win = 1'b0;
    fixed_pix(0, 0);
    fixed_pix(0, 0);
    run_ticks(90);
    fixed_pix(0, 0);
    fixed_pix(XP + 100, YP + 60);

    // Clear and new result together: clear wins; held result restarts reveal
    clear = 1'b1; black_win = 1'b1; rand_pix(); step();
    clear = 1'b0; rand_pix(); step();
    black_win = 1'b0;
    run_ticks(6);

    // Reset mid-reveal discards progress; new result restarts from zero rows
    rst = 1'b1; rand_pix(); step(); rst = 1'b0;
    pix_cycles(4);
    draw_game = 1'b1; rand_pix(); step(); draw_game = 1'b0;
    run_ticks(5);
    clear = 1'b1; rand_pix(); step(); clear = 1'b0;
    pix_cycles(6);

    // Drain outstanding expectations
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (q_vga.size() != 0 || q_busy.size() != 0) begin
      n_err++;
      $display("FAIL drain leftover vga=%0d busy=%0d expected 0", q_vga.size(), q_busy.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
